// File: rtl/priority_scan_encoder.sv
// Captures a request vector and emits the index of each set bit, one per beat, MSB- or LSB-first.
// One cycle from acceptance to the first beat; out_ready low stalls the beat, and in_ready stays low until the last beat transfers.
module priority_scan_encoder #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic             r_order;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic             r_none;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_vec;
  logic             w_ord;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_single;
  logic [CNT_W-1:0] w_pop;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_xfer   = out_ready && (r_state == S_EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_EMIT;
      S_EMIT: if (w_xfer && r_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The vector the next beat is chosen from: the fresh request on acceptance,
  // otherwise what remains after clearing the bit being transferred.
  always_comb begin
    w_vec = r_pending & ~(WIDTH'(1) << r_idx);
    w_ord = r_order;
    if (w_accept) begin
      w_vec = in_vec;
      w_ord = in_lsb_first;
    end
  end

  always_comb begin
    w_sel_idx = '0;
    if (w_ord) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (w_vec[i]) w_sel_idx = IDX_W'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (w_vec[i]) w_sel_idx = IDX_W'(i);
    end
  end

  assign w_single = (w_vec != '0) && ((w_vec & (w_vec - WIDTH'(1))) == '0);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + CNT_W'(in_vec[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_order   <= 1'b0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_none    <= 1'b0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_pending <= in_vec;
      r_order   <= in_lsb_first;
      r_count   <= w_pop;
      r_none    <= (in_vec == '0);
      r_idx     <= w_sel_idx;
      r_last    <= w_single || (in_vec == '0);
    end else if (w_xfer) begin
      r_pending <= w_vec;
      if (!r_last) begin
        r_idx  <= w_sel_idx;
        r_last <= w_single;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_EMIT);
  assign busy      = (r_state == S_EMIT);
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign out_none  = r_none;
  assign out_count = r_count;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench for priority_scan_encoder: expected beat lists are built from a list-based
// reference model at acceptance time and popped by a monitor whenever a beat is presented.
module tb_priority_scan_encoder;

  localparam int WIDTH = 16;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             none;
    logic [CNT_W-1:0] count;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec = '0;
  logic             in_lsb_first = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_none;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    beats_xfer = 0;
  int    last_xfer_edge = -100;
  bit    rdy_rand = 1'b0;
  beat_t exp_q[$];

  priority_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_lsb_first(in_lsb_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .out_none(out_none), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 99) < 65);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list the set positions in the requested order.
  task automatic model_push(input logic [WIDTH-1:0] v, input logic lsb);
    int    pos[$];
    beat_t b;
    for (int i = 0; i < WIDTH; i++) if (v[i]) pos.push_back(i);
    if (!lsb) pos.reverse();
    if (pos.size() == 0) begin
      b.idx = '0; b.last = 1'b1; b.none = 1'b1; b.count = '0;
      exp_q.push_back(b);
    end else begin
      foreach (pos[k]) begin
        b.idx   = IDX_W'(pos[k]);
        b.last  = (k == pos.size() - 1);
        b.none  = 1'b0;
        b.count = CNT_W'(pos.size());
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      chk("in_ready_vs_valid", in_ready, !out_valid);
      chk("busy_vs_valid", busy, out_valid);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q[0];
          chk("beat", {out_idx, out_last, out_none, out_count}, e);
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats_xfer++;
            if (e.last) last_xfer_edge = cyc + 1;
          end
        end
      end
    end
  end

  // Offer a vector; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [WIDTH-1:0] v, input logic lsb);
    bit waited = 0;
    bit done = 0;
    int acc_edge;
    in_valid = 1'b1; in_vec = v; in_lsb_first = lsb;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(v, lsb);
        acc_edge = cyc + 1;
        done = 1;
      end else begin
        waited = 1;
      end
    end
    if (!done) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_vec = $urandom;
      chk("first_beat_latency", out_valid, 1);
      if (waited) chk("accept_after_last", acc_edge, last_xfer_edge + 1);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    else chk("idle_after_last", in_ready, 1);
  endtask

  initial begin
    int base;
    logic [WIDTH-1:0] v;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_idx, out_last, out_none, out_count, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: MSB-first, LSB-first, zero vector
    send(16'h8421, 1'b0); drain();
    send(16'h8421, 1'b1); drain();
    send(16'h0000, 1'b0); drain();

    // Stall pattern 0,0,1,0,1
    out_ready = 1'b0;
    base = beats_xfer;
    send(16'h0300, 1'b0);
    out_ready = 1'b0; @(posedge clk); #1;
    out_ready = 1'b0; @(posedge clk); #1;
    out_ready = 1'b1; @(posedge clk); #1;
    out_ready = 1'b0; @(posedge clk); #1;
    out_ready = 1'b1; @(posedge clk); #1;
    chk("stall_beats", beats_xfer - base, 2);
    chk("stall_done_idle", in_ready, 1);

    // Full vector followed by a vector held pending
    send(16'hFFFF, 1'b0);
    send(16'h1234, 1'b1);
    drain();

    // Reset in the middle of a vector
    send(16'h00F0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_busy", busy, 0);
    base = beats_xfer;
    repeat (5) @(posedge clk);
    #1 chk("no_stale_beats", beats_xfer - base, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Randomized traffic with random backpressure
    rdy_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 4))
        0: v = '0;
        1: v = '1;
        2: v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        3: v = WIDTH'($urandom);
        default: v = WIDTH'($urandom) & WIDTH'($urandom);
      endcase
      send(v, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
